// File: rtl/md5_pkg.sv
// Shared widths, FSM encoding and a small saturating-add helper for the
// MD5 candidate dispatcher and result matcher.
package md5_pkg;

   localparam int MD5_MSG_W    = 448;
   localparam int MD5_DIGEST_W = 128;
   localparam int MATCH_CNT_W  = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   // Add a per-cycle hit count (at most 16) to the 8-bit match counter,
   // clamping at 255.
   function automatic logic [MATCH_CNT_W-1:0] sat_add8(
      input logic [MATCH_CNT_W-1:0] acc,
      input logic [4:0]             inc
   );
      logic [MATCH_CNT_W:0] sum;
      sum = {1'b0, acc} + {4'b0000, inc};
      return sum[MATCH_CNT_W] ? {MATCH_CNT_W{1'b1}} : sum[MATCH_CNT_W-1:0];
   endfunction

endpackage

// File: rtl/md5_dispatch_match_rr_idle_pick.sv
// Round-robin first-idle selector: starting at the pointer and wrapping,
// grant the first core whose busy bit is clear.
module rr_idle_pick #(
   parameter int N     = 4,
   parameter int PTR_W = 2
) (
   input  logic [N-1:0]     busy_i,
   input  logic [PTR_W-1:0] ptr_i,
   output logic [N-1:0]     grant_o,
   output logic             found_o
);

   int               idx;
   logic [PTR_W-1:0] sel;

   // Scan N positions from the pointer; the first idle core wins.
   // NOTE: every output and temporary gets a default before the loop so no latch is inferred.
   always_comb begin
      grant_o = '0;
      found_o = 1'b0;
      idx     = 0;
      sel     = '0;
      for (int k = 0; k < N; k++) begin
         idx = int'(ptr_i) + k;
         if (idx >= N) begin
            idx = idx - N;
         end
         sel = PTR_W'(idx);
         if (!found_o && !busy_i[sel]) begin
            grant_o[sel] = 1'b1;
            found_o      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/md5_dispatch_match.sv
// Dispatches padded candidate blocks to a pool of MD5 cores, tracks which
// cores are busy, and compares returned digests against a target hash.
module md5_dispatch_match
   import md5_pkg::*;
#(
   parameter int NUM_CORES = 4,
   parameter int TAG_W     = 16,
   parameter int LEN_W     = 16
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              start,
   input  logic [MD5_DIGEST_W-1:0]           target_hash,
   input  logic [MD5_MSG_W-1:0]              in_msg,
   input  logic [LEN_W-1:0]                  in_len,
   input  logic [TAG_W-1:0]                  in_tag,
   input  logic                              in_valid,
   input  logic                              in_last,
   output logic                              in_ready,
   output logic [MD5_MSG_W-1:0]              core_msg,
   output logic [LEN_W-1:0]                  core_len,
   output logic [NUM_CORES-1:0]              core_valid,
   input  logic [NUM_CORES*MD5_DIGEST_W-1:0] core_digest,
   input  logic [NUM_CORES-1:0]              core_done,
   output logic                              done,
   output logic                              match,
   output logic [TAG_W-1:0]                  match_tag,
   output logic [MATCH_CNT_W-1:0]            match_count,
   output logic                              protocol_err
);

   localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

   state_e                   state_q, state_d;
   logic [MD5_DIGEST_W-1:0]  target_q;
   logic [NUM_CORES-1:0]     busy_q, busy_d;
   logic [PTR_W-1:0]         ptr_q, ptr_d;
   logic [TAG_W-1:0]         tag_q [NUM_CORES];

   logic [MD5_MSG_W-1:0]     core_msg_q;
   logic [LEN_W-1:0]         core_len_q;
   logic [NUM_CORES-1:0]     core_valid_q;
   logic                     done_q;
   logic                     match_q;
   logic [TAG_W-1:0]         match_tag_q;
   logic [MATCH_CNT_W-1:0]   match_count_q;
   logic                     perr_q;

   logic [NUM_CORES-1:0]     grant;
   logic                     found;
   logic                     accept;
   logic                     start_ok;
   logic [PTR_W-1:0]         grant_idx;
   logic [NUM_CORES-1:0]     done_ok;
   logic [NUM_CORES-1:0]     done_bad;
   logic [4:0]               hit_cnt;
   logic                     any_hit;
   logic [TAG_W-1:0]         first_tag;

   rr_idle_pick #(
      .N     (NUM_CORES),
      .PTR_W (PTR_W)
   ) u_pick (
      .busy_i  (busy_q),
      .ptr_i   (ptr_q),
      .grant_o (grant),
      .found_o (found)
   );

   assign in_ready = (state_q == ST_RUN) && found;
   assign accept   = in_valid && in_ready;
   // start is honoured only between batches; in RUN/DRAIN it is dropped.
   assign start_ok = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

   // Convert the one-hot grant into the index used to advance the pointer.
   always_comb begin
      grant_idx = '0;
      for (int i = 0; i < NUM_CORES; i++) begin
         if (grant[i]) begin
            grant_idx = PTR_W'(i);
         end
      end
   end

   // Qualify completions against the busy map, count hits and pick the
   // tag of the lowest-index hitting core (descending scan, last write wins).
   always_comb begin
      done_ok   = core_done & busy_q;
      done_bad  = core_done & ~busy_q;
      hit_cnt   = '0;
      any_hit   = 1'b0;
      first_tag = '0;
      for (int i = NUM_CORES - 1; i >= 0; i--) begin
         if (done_ok[i] &&
             (core_digest[i*MD5_DIGEST_W +: MD5_DIGEST_W] == target_q)) begin
            hit_cnt   = hit_cnt + 5'd1;
            any_hit   = 1'b1;
            first_tag = tag_q[i];
         end
      end
   end

   // Busy map and round-robin pointer: completions clear, an issue sets;
   // an issue to a core completing in the same cycle leaves it busy.
   always_comb begin
      busy_d = busy_q & ~done_ok;
      ptr_d  = ptr_q;
      if (accept) begin
         busy_d = busy_d | grant;
         if (grant_idx == PTR_W'(NUM_CORES - 1)) begin
            ptr_d = '0;
         end else begin
            ptr_d = grant_idx + PTR_W'(1);
         end
      end
   end

   // Batch FSM next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (start) state_d = ST_RUN;
         ST_RUN:   if (accept && in_last) state_d = ST_DRAIN;
         ST_DRAIN: if (busy_q == '0) state_d = ST_DONE;
         ST_DONE:  if (start) state_d = ST_RUN;
         default:  state_d = ST_IDLE;
      endcase
   end

   // FSM, busy map, pointer and the registered issue bus.
   // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         busy_q       <= '0;
         ptr_q        <= '0;
         core_valid_q <= '0;
         core_msg_q   <= '0;
         core_len_q   <= '0;
      end else begin
         state_q      <= state_d;
         busy_q       <= busy_d;
         ptr_q        <= ptr_d;
         core_valid_q <= accept ? grant : '0;
         if (accept) begin
            core_msg_q <= in_msg;
            core_len_q <= in_len;
         end
      end
   end

   // Per-core tag storage, written on issue.
   // NOTE: no reset here; a tag is only read while its busy bit is set, and busy is reset.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_CORES; i++) begin
         if (accept && grant[i]) begin
            tag_q[i] <= in_tag;
         end
      end
   end

   // Target latch and result registers; cleared by an accepted start.
   always_ff @(posedge clk) begin
      if (reset) begin
         target_q      <= '0;
         match_q       <= 1'b0;
         match_tag_q   <= '0;
         match_count_q <= '0;
         done_q        <= 1'b0;
      end else begin
         done_q <= (state_d == ST_DONE);
         if (start_ok) begin
            target_q      <= target_hash;
            match_q       <= 1'b0;
            match_tag_q   <= '0;
            match_count_q <= '0;
         end else begin
            if (any_hit && !match_q) begin
               match_q     <= 1'b1;
               match_tag_q <= first_tag;
            end
            match_count_q <= sat_add8(match_count_q, hit_cnt);
         end
      end
   end

   // Sticky flag for a completion strobe from a core that was not busy.
   always_ff @(posedge clk) begin
      if (reset) begin
         perr_q <= 1'b0;
      end else if (done_bad != '0) begin
         perr_q <= 1'b1;
      end
   end

   assign core_msg     = core_msg_q;
   assign core_len     = core_len_q;
   assign core_valid   = core_valid_q;
   assign done         = done_q;
   assign match        = match_q;
   assign match_tag    = match_tag_q;
   assign match_count  = match_count_q;
   assign protocol_err = perr_q;

endmodule
